// File: rtl/bcd_conv_sched_pkg.sv
// Shared types and constants for the BCD converter scheduler: FSM states,
// operand ceiling and the digit layout of the packed BCD result.
package bcd_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RELEASE
    } state_t;

    localparam int BCD_MAX = 9999;

    // bcd_out / conv_bcd packing: {thousands, hundreds, tens, ones}
    localparam int DIGIT_W   = 4;
    localparam int ONES_LSB  = 0;
    localparam int TENS_LSB  = 4;
    localparam int HUNDS_LSB = 8;
    localparam int THOUS_LSB = 12;

endpackage

// File: rtl/bcd_conv_sched_if.sv
// Requester-side bus of the BCD converter scheduler. The master modport is the
// requester group (watch mode logic); the slave modport is the scheduler.
interface bcd_conv_sched_if #(
    parameter int N_REQ = 4,
    parameter int DW    = 14
);
    logic [N_REQ-1:0]    req;
    logic [N_REQ*DW-1:0] din;
    logic [N_REQ-1:0]    ack;
    logic                err;
    logic [15:0]         bcd_out;
    logic                busy;

    modport master (
        output req, din,
        input  ack, err, bcd_out, busy
    );

    modport slave (
        input  req, din,
        output ack, err, bcd_out, busy
    );
endinterface

// File: rtl/bcd_conv_sched_rr_pick.sv
// Combinational round-robin picker: returns the first set request at or after
// the pointer, wrapping modulo N_REQ. Shared by the shared-resource schedulers.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [IW-1:0]    grant,
    output logic             any
);
    logic [IW-1:0] slot;

    // Scan from the farthest slot back toward the pointer so the nearest hit wins.
    always_comb begin
        // NOTE: every output gets a default before the loop, so no path leaves it unassigned (no latch).
        grant = '0;
        any   = 1'b0;
        slot  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            slot = IW'((int'(ptr) + k) % N_REQ);
            if (req[slot]) begin
                any   = 1'b1;
                grant = slot;
            end
        end
    end
endmodule

// File: rtl/bcd_conv_sched.sv
// Round-robin scheduler sharing one 4-digit binary-to-BCD converter among
// several display requesters, with operand clamping, start/done sequencing and timeout.
module bcd_conv_sched
    import bcd_sched_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int DW      = 14,
    parameter int TIMEOUT = 32,
    parameter int GAP     = 2
) (
    input  logic            clk,
    input  logic            rst,
    bcd_conv_sched_if.slave bus,
    output logic            conv_start,
    output logic [DW-1:0]   conv_din,
    input  logic            conv_done,
    input  logic [15:0]     conv_bcd
);
    localparam int IW   = $clog2(N_REQ);
    localparam int CMAX = (TIMEOUT > GAP) ? TIMEOUT : GAP;
    localparam int CW   = $clog2(CMAX + 2);

    state_t        state, state_nxt;
    logic [IW-1:0] ptr, gnt, pick_idx;
    logic          pick_any;
    logic [CW-1:0] cnt;
    logic [DW-1:0] op_sel, op_clamped;
    logic          grab, take, abort, leave;
    logic          timed_out, gap_met;

    rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .req   (bus.req),
        .ptr   (ptr),
        .grant (pick_idx),
        .any   (pick_any)
    );

    always_comb begin
        op_sel = '0;
        for (int i = 0; i < N_REQ; i++)
            if (pick_idx == IW'(i)) op_sel = bus.din[i*DW +: DW];
    end

    assign op_clamped = (op_sel > DW'(BCD_MAX)) ? DW'(BCD_MAX) : op_sel;
    assign timed_out  = (cnt == CW'(TIMEOUT));
    assign gap_met    = (cnt >= CW'(GAP));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_any) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (conv_done || timed_out) state_nxt = RELEASE;
            RELEASE: if (!conv_done && gap_met) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A done seen on the timeout edge still counts as a good result.
    always_comb begin
        bus.busy = (state != IDLE);
        grab     = (state == IDLE) && pick_any;
        take     = (state == WAIT) && conv_done;
        abort    = (state == WAIT) && !conv_done && timed_out;
        leave    = (state == RELEASE) && !conv_done && gap_met;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr         <= '0;
            gnt         <= '0;
            cnt         <= '0;
            conv_start  <= 1'b0;
            conv_din    <= '0;
            bus.ack     <= '0;
            bus.err     <= 1'b0;
            bus.bcd_out <= '0;
        end else begin
            bus.ack <= '0;
            bus.err <= 1'b0;

            if (grab) begin
                gnt      <= pick_idx;
                conv_din <= op_clamped;
            end

            if (state == ISSUE) begin
                conv_start <= 1'b1;
                cnt        <= '0;
            end

            if (take || abort) begin
                conv_start <= 1'b0;
                cnt        <= '0;
                bus.ack    <= N_REQ'(1) << gnt;
            end
            if (take)  bus.bcd_out <= conv_bcd;
            if (abort) bus.err     <= 1'b1;

            if (state == WAIT && !take && !abort) cnt <= cnt + CW'(1);

            // RELEASE only needs to know the gap has elapsed, so the count saturates there.
            if (state == RELEASE && !leave && !gap_met) cnt <= cnt + CW'(1);

            if (leave) ptr <= (gnt == IW'(N_REQ - 1)) ? '0 : gnt + IW'(1);
        end
    end
endmodule

// File: tb/tb_bcd_conv_sched.sv
// Self-checking bench for bcd_conv_sched: behavioural converter model plus a
// round-robin/clamp reference computed from plain arithmetic.
module tb_bcd_conv_sched;
    import bcd_sched_pkg::*;

    localparam int N       = 4;
    localparam int DW      = 14;
    localparam int TIMEOUT = 32;
    localparam int GAP     = 2;
    localparam int DLY     = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          conv_start, conv_done;
    logic [DW-1:0] conv_din;
    logic [15:0]   conv_bcd;

    bcd_conv_sched_if #(.N_REQ(N), .DW(DW)) bus ();

    bcd_conv_sched #(
        .N_REQ   (N),
        .DW      (DW),
        .TIMEOUT (TIMEOUT),
        .GAP     (GAP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .conv_start (conv_start),
        .conv_din   (conv_din),
        .conv_done  (conv_done),
        .conv_bcd   (conv_bcd)
    );

    initial forever #5 clk = ~clk;

    int            total = 0;
    int            bad   = 0;
    int            hold_len = 8;
    bit            stall = 1'b0;
    int            tick;
    logic          st_prev;
    logic [DW-1:0] cm_op;
    int            low_run, last_low, done_idle_hits, ptr_m;
    logic          st_seen, rose;
    logic [DW-1:0] rise_din;
    logic [15:0]   exp_bcd;
    int            obs_idx, obs_lat;
    logic          obs_err;
    logic [15:0]   obs_bcd;
    int            ops[N];

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r = '0;
        r[THOUS_LSB +: DIGIT_W] = 4'((v / 1000) % 10);
        r[HUNDS_LSB +: DIGIT_W] = 4'((v / 100) % 10);
        r[TENS_LSB  +: DIGIT_W] = 4'((v / 10) % 10);
        r[ONES_LSB  +: DIGIT_W] = 4'(v % 10);
        return r;
    endfunction

    function automatic int clamp(input int v);
        return (v > BCD_MAX) ? BCD_MAX : v;
    endfunction

    function automatic int rr_next(input logic [N-1:0] pend, input int p);
        for (int k = 0; k < N; k++)
            if (pend[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Converter: done rises DLY clocks after the start edge, stays high hold_len clocks.
    initial begin
        conv_done = 1'b0;
        conv_bcd  = '0;
        tick      = 0;
        st_prev   = 1'b0;
        cm_op     = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                conv_done = 1'b0;
                tick      = 0;
                st_prev   = 1'b0;
            end else begin
                if (conv_start && !st_prev) begin
                    tick  = 1;
                    cm_op = conv_din;
                end else if (tick != 0) begin
                    tick++;
                end
                st_prev = conv_start;
                if (tick == DLY + 1 && !stall) begin
                    conv_done = 1'b1;
                    conv_bcd  = to_bcd(int'(cm_op));
                end
                if (tick == DLY + 1 + hold_len) begin
                    conv_done = 1'b0;
                    tick      = 0;
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
        rose = conv_start && !st_seen;
        if (rose) begin
            last_low = low_run;
            rise_din = conv_din;
        end
        low_run = conv_start ? 0 : low_run + 1;
        st_seen = conv_start;
        if (conv_done && !bus.busy) done_idle_hits++;
    endtask

    task automatic wait_ack();
        bit got;
        int rise_c, ones;
        got = 1'b0; rise_c = -1; ones = 0;
        obs_idx = -1; obs_err = 1'b0; obs_bcd = '0; obs_lat = -1;
        for (int c = 0; c < 300 && !got; c++) begin
            step();
            if (rose) rise_c = c;
            if (bus.ack != '0) begin
                got     = 1'b1;
                obs_err = bus.err;
                obs_bcd = bus.bcd_out;
                obs_lat = c - rise_c;
                for (int i = 0; i < N; i++)
                    if (bus.ack[i]) begin
                        ones++;
                        obs_idx    = i;
                        bus.req[i] = 1'b0;
                    end
            end
        end
        check("ack_seen", 32'(got), 1);
        check("ack_onehot", ones, 1);
    endtask

    task automatic serve(input logic [N-1:0] mask, input bit check_lat);
        logic [N-1:0] pend;
        int           g;
        pend = mask;
        for (int i = 0; i < N; i++)
            if (mask[i]) bus.din[i*DW +: DW] = DW'(ops[i]);
        bus.req = mask;
        for (int k = 0; k < N && pend != '0; k++) begin
            g = rr_next(pend, ptr_m);
            wait_ack();
            check("grant_order", obs_idx, g);
            check("conv_din_clamped", rise_din, clamp(ops[g]));
            exp_bcd = to_bcd(clamp(ops[g]));
            check("bcd_out", obs_bcd, exp_bcd);
            check("err_clear", obs_err, 0);
            check("start_low_gap", 32'(last_low >= GAP), 1);
            if (check_lat) check("ack_latency", obs_lat, 11);
            pend[g] = 1'b0;
            ptr_m   = (g + 1) % N;
            step();
            check("ack_width", bus.ack, 0);
        end
        bus.req = '0;
        repeat (30) step();
        check("busy_idle", bus.busy, 0);
        check("start_idle", conv_start, 0);
    endtask

    initial begin
        rst = 1'b1;
        bus.req = '0; bus.din = '0;
        low_run = 0; last_low = 0; st_seen = 1'b0; rose = 1'b0; rise_din = '0;
        done_idle_hits = 0; ptr_m = 0; exp_bcd = '0;
        repeat (3) step();

        check("rst_ack", bus.ack, 0);
        check("rst_err", bus.err, 0);
        check("rst_bcd", bus.bcd_out, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_start", conv_start, 0);
        check("rst_din", conv_din, 0);
        rst = 1'b0;
        step();

        ops[1] = 1234;
        serve(4'b0010, 1'b1);

        rst = 1'b1; step(); rst = 1'b0; step();
        ptr_m = 0; exp_bcd = '0;
        ops = '{5, 60, 700, 8000};
        serve(4'b1111, 1'b1);

        ops[0] = 12000;
        serve(4'b0001, 1'b0);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < N; i++) ops[i] = int'($urandom_range(0, 16383));
            serve(4'($urandom_range(1, 15)), 1'b1);
        end

        // Stalled converter: abort with err, result register untouched.
        stall = 1'b1;
        bus.din[2*DW +: DW] = DW'($urandom_range(0, 9999));
        bus.req = 4'b0100;
        wait_ack();
        check("timeout_grant", obs_idx, 2);
        check("timeout_err", obs_err, 1);
        check("timeout_latency", obs_lat, TIMEOUT + 1);
        check("timeout_bcd_kept", obs_bcd, exp_bcd);
        step();
        check("timeout_err_width", bus.err, 0);
        bus.req = '0;
        stall = 1'b0;
        ptr_m = 3;
        repeat (8) step();
        check("timeout_busy_idle", bus.busy, 0);

        // Lingering done must hold the scheduler in RELEASE.
        hold_len = 20;
        ops[0] = int'($urandom_range(0, 9999));
        ops[1] = int'($urandom_range(0, 9999));
        serve(4'b0011, 1'b1);
        check("stale_gap", 32'(last_low >= hold_len), 1);
        hold_len = 8;

        ops[1] = 4321;
        serve(4'b0010, 1'b1);
        bus.din[3*DW +: DW] = DW'(777);
        bus.req = 4'b1000;
        for (int c = 0; c < 20 && !conv_start; c++) step();
        check("start_before_reset", conv_start, 1);
        repeat (3) step();
        rst = 1'b1;
        #1;
        check("midrst_ack", bus.ack, 0);
        check("midrst_err", bus.err, 0);
        check("midrst_bcd", bus.bcd_out, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_start", conv_start, 0);
        check("midrst_din", conv_din, 0);
        bus.req = '0;
        step(); step();
        check("midrst_no_ack", bus.ack, 0);
        rst = 1'b0;
        ptr_m = 0; exp_bcd = '0;
        step();
        ops[1] = int'($urandom_range(0, 16383));
        ops[3] = int'($urandom_range(0, 16383));
        serve(4'b1010, 1'b1);

        check("done_while_idle", done_idle_hits, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
